// File: rtl/fir_mac_sequencer.sv
// Per-sample scheduler for a folded symmetric FIR sharing one pre-adder/MAC:
// shift strobe, one MAC command per tap pair, pipeline drain, then y load.
module fir_mac_sequencer #(
  parameter int unsigned N_TAPS  = 21,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned IDX_W   = (((N_TAPS + 1) / 2) > 1) ? $clog2((N_TAPS + 1) / 2) : 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sam_clk_en,
  input  logic             enable,
  output logic             shift_en,
  output logic             mac_en,
  output logic             acc_clr,
  output logic             center,
  output logic [IDX_W-1:0] tap_idx,
  output logic             y_load,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned NPAIR = (N_TAPS + 1) / 2;
  localparam int unsigned DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAIR - 1);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam bit ODD = (N_TAPS % 2) == 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [DRN_W-1:0] drn_cnt;
  logic             req;

  assign req = sam_clk_en & enable;

  // tap_idx doubles as the RUN pass counter; drn_cnt counts MAC pipeline latency
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= IDLE;
      drn_cnt  <= '0;
      shift_en <= 1'b0;
      mac_en   <= 1'b0;
      acc_clr  <= 1'b0;
      center   <= 1'b0;
      tap_idx  <= '0;
      y_load   <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      acc_clr  <= 1'b0;
      center   <= 1'b0;
      y_load   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state    <= SHIFT;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (req) overrun <= 1'b1;
          state   <= RUN;
          mac_en  <= 1'b1;
          acc_clr <= 1'b1;
          tap_idx <= '0;
          center  <= ODD && (NPAIR == 1);
        end
        RUN: begin
          if (req) overrun <= 1'b1;
          if (tap_idx == LAST_IDX) begin
            mac_en  <= 1'b0;
            drn_cnt <= '0;
            if (MAC_LAT == 0) begin
              state  <= DONE;
              y_load <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            tap_idx <= tap_idx + IDX_W'(1);
            center  <= ODD && ((tap_idx + IDX_W'(1)) == LAST_IDX);
          end
        end
        DRAIN: begin
          if (req) overrun <= 1'b1;
          if (drn_cnt == LAST_DRN) begin
            state  <= DONE;
            y_load <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt + DRN_W'(1);
          end
        end
        DONE: begin
          // a request landing on the y_load cycle chains straight into the next sample
          if (req) begin
            state    <= SHIFT;
            shift_en <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mac_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
